// File: rtl/bus_pkg.sv
// Shared widths and master-ID encoding for the core-local req/ack/resp bus.
package bus_pkg;
    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;

    typedef logic [0:0] id_t;

    localparam id_t ID_M0 = 1'b0;
    localparam id_t ID_M1 = 1'b1;
endpackage

// File: rtl/bus_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads.
// The head is visible combinationally so responses can be routed with zero added latency.
module bus_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (!do_push && do_pop)
            count_d = count_q - 1'b1;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/bus_arb2.sv
// Two-master, one-slave round-robin arbiter with in-order read-response routing.
module bus_arb2 import bus_pkg::*; #(
    parameter int RD_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [BUS_AW-1:0]  m0_addr,
    input  logic [BUS_BEW-1:0] m0_be,
    input  logic [BUS_DW-1:0]  m0_wdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [BUS_AW-1:0]  m1_addr,
    input  logic [BUS_BEW-1:0] m1_be,
    input  logic [BUS_DW-1:0]  m1_wdata,
    output logic               m0_ack,
    output logic               m0_resp,
    output logic [BUS_DW-1:0]  m0_rdata,
    output logic               m1_ack,
    output logic               m1_resp,
    output logic [BUS_DW-1:0]  m1_rdata,
    output logic               s_req,
    output logic               s_we,
    output logic [BUS_AW-1:0]  s_addr,
    output logic [BUS_BEW-1:0] s_be,
    output logic [BUS_DW-1:0]  s_wdata,
    input  logic               s_ack,
    input  logic               s_resp,
    input  logic [BUS_DW-1:0]  s_rdata,
    output logic               err_o
);
    id_t                last_q, last_d, grant_id, head_id;
    logic               grant_valid, g_we, blk, hs;
    logic               fifo_full, fifo_empty, resp_ok;
    logic               err_q, err_d;
    logic [BUS_AW-1:0]  g_addr;
    logic [BUS_BEW-1:0] g_be;
    logic [BUS_DW-1:0]  g_wdata;

    // Reset gates the grant so no request or ack escapes while rst_i is low.
    always_comb begin
        grant_valid = rst_i & (m0_req | m1_req);
        if (m0_req && m1_req)
            grant_id = ~last_q;
        else if (m1_req)
            grant_id = ID_M1;
        else
            grant_id = ID_M0;
    end

    assign g_we    = (grant_id == ID_M1) ? m1_we    : m0_we;
    assign g_addr  = (grant_id == ID_M1) ? m1_addr  : m0_addr;
    assign g_be    = (grant_id == ID_M1) ? m1_be    : m0_be;
    assign g_wdata = (grant_id == ID_M1) ? m1_wdata : m0_wdata;

    // A full ID FIFO holds reads back even if a response pops it this cycle.
    assign blk     = grant_valid & ~g_we & fifo_full;
    assign s_req   = grant_valid & ~blk;
    assign s_we    = grant_valid & g_we;
    assign s_addr  = grant_valid ? g_addr  : '0;
    assign s_be    = grant_valid ? g_be    : '0;
    assign s_wdata = grant_valid ? g_wdata : '0;

    assign hs     = s_req & s_ack;
    assign m0_ack = hs & (grant_id == ID_M0);
    assign m1_ack = hs & (grant_id == ID_M1);

    assign resp_ok  = rst_i & s_resp & ~fifo_empty;
    assign m0_resp  = resp_ok & (head_id == ID_M0);
    assign m1_resp  = resp_ok & (head_id == ID_M1);
    assign m0_rdata = m0_resp ? s_rdata : '0;
    assign m1_rdata = m1_resp ? s_rdata : '0;

    assign last_d = hs ? grant_id : last_q;
    assign err_d  = err_q | (s_resp & fifo_empty);
    assign err_o  = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= ID_M0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    bus_id_fifo #(
        .WIDTH ($bits(id_t)),
        .DEPTH (RD_DEPTH)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs & ~g_we),
        .din_i   (grant_id),
        .pop_i   (resp_ok),
        .dout_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_bus_arb2.sv
// Scenario bench for bus_arb2: expected read responses are queued at request time
// and retired against the DUT's response pulses.
module tb_bus_arb2;
    import bus_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_resp, m1_ack, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack, s_resp;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        err_o;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [31:0] next_data = 32'h100;

    always #5 clk_i = ~clk_i;

    bus_arb2 #(.RD_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
        .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata), .err_o(err_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 0; m1_wdata = 0;
        s_ack = 0; s_resp = 0; s_rdata = 0;
    endtask

    task automatic set_m(input int id, input logic we, input logic [31:0] addr);
        if (id == 0) begin
            m0_req = 1; m0_we = we; m0_addr = addr; m0_be = 4'hF; m0_wdata = addr ^ 32'hA5A5_0000;
        end else begin
            m1_req = 1; m1_we = we; m1_addr = addr; m1_be = 4'h3; m1_wdata = addr ^ 32'h5A5A_0000;
        end
    endtask

    task automatic test_reset();
        idle();
        set_m(0, 0, 32'h40);
        s_ack = 1; s_resp = 1; s_rdata = 32'h77;
        #3;
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL reset_m0_ack got=%b exp=0", m0_ack); end
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
        checks++; if (m0_resp !== 1'b0) begin failures++; $display("FAIL reset_m0_resp got=%b exp=0", m0_resp); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        step();
        idle();
        step();
        rst_i = 1;
        step();
    endtask

    task automatic test_drain();
        exp_t        e;
        logic [31:0] got, oth;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s_resp = 1; s_rdata = e.data;
            #3;
            got = e.id ? m1_rdata : m0_rdata;
            oth = e.id ? m0_rdata : m1_rdata;
            $display("resp id=%0d data=%h", e.id, e.data);
            checks++; if (m0_resp !== (e.id == 1'b0)) begin failures++; $display("FAIL drain_m0_resp got=%b exp=%b", m0_resp, e.id == 1'b0); end
            checks++; if (m1_resp !== (e.id == 1'b1)) begin failures++; $display("FAIL drain_m1_resp got=%b exp=%b", m1_resp, e.id == 1'b1); end
            checks++; if (got !== e.data) begin failures++; $display("FAIL drain_rdata id=%0d got=%h exp=%h", e.id, got, e.data); end
            checks++; if (oth !== 32'h0) begin failures++; $display("FAIL drain_other_rdata got=%h exp=0", oth); end
            step();
        end
        s_resp = 0; s_rdata = 0;
    endtask

    task automatic test_single_read();
        idle();
        set_m(0, 0, 32'h10);
        s_ack = 1;
        #3;
        checks++; if (s_req !== 1'b1) begin failures++; $display("FAIL single_s_req got=%b exp=1", s_req); end
        checks++; if (s_addr !== 32'h10) begin failures++; $display("FAIL single_s_addr got=%h exp=10", s_addr); end
        checks++; if (s_be !== 4'hF || s_wdata !== (32'h10 ^ 32'hA5A5_0000)) begin failures++; $display("FAIL single_s_be_wdata got=%h/%h", s_be, s_wdata); end
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL single_m0_ack got=%b exp=1", m0_ack); end
        checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL single_m1_ack got=%b exp=0", m1_ack); end
        exp_q.push_back('{id: 1'b0, data: 32'h5});
        step();
        idle();
        #3;
        checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL single_ack_pulse got=%b exp=0", m0_ack); end
        step();
        test_drain();
        #3;
        checks++; if (m0_resp !== 1'b0) begin failures++; $display("FAIL single_resp_pulse got=%b exp=0", m0_resp); end
        step();
    endtask

    task automatic test_round_robin();
        logic exp_g;
        idle();
        set_m(0, 1, 32'h1000);
        set_m(1, 1, 32'h2000);
        s_ack = 1;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0);
            #3;
            $display("rr cycle=%0d m0_ack=%b m1_ack=%b", i, m0_ack, m1_ack);
            checks++; if (m1_ack !== exp_g) begin failures++; $display("FAIL rr_m1_ack cyc=%0d got=%b exp=%b", i, m1_ack, exp_g); end
            checks++; if (m0_ack !== !exp_g) begin failures++; $display("FAIL rr_m0_ack cyc=%0d got=%b exp=%b", i, m0_ack, !exp_g); end
            checks++; if (s_addr !== (exp_g ? 32'h2000 : 32'h1000)) begin failures++; $display("FAIL rr_s_addr cyc=%0d got=%h", i, s_addr); end
            step();
        end
        idle();
    endtask

    task automatic test_fifo_full();
        exp_t e;
        idle();
        s_ack = 1;
        for (int i = 0; i < 4; i++) begin
            set_m(1, 0, 32'h300 + i);
            #3;
            checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL full_fill_ack i=%0d got=%b exp=1", i, m1_ack); end
            exp_q.push_back('{id: 1'b1, data: next_data});
            next_data++;
            step();
        end
        set_m(1, 0, 32'h304);
        #3;
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL full_block_s_req got=%b exp=0", s_req); end
        checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL full_block_ack got=%b exp=0", m1_ack); end
        step();
        set_m(0, 1, 32'h500);
        #3;
        checks++; if (m0_ack !== 1'b1 || s_we !== 1'b1) begin failures++; $display("FAIL full_write_ack got=%b/%b exp=1/1", m0_ack, s_we); end
        checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL full_write_m1_ack got=%b exp=0", m1_ack); end
        step();
        m0_req = 0;
        e = exp_q.pop_front();
        s_resp = 1; s_rdata = e.data;
        #3;
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL full_pop_block got=%b exp=0", s_req); end
        checks++; if (m1_resp !== 1'b1 || m1_rdata !== e.data) begin failures++; $display("FAIL full_pop_resp got=%b/%h exp=1/%h", m1_resp, m1_rdata, e.data); end
        step();
        s_resp = 0; s_rdata = 0;
        #3;
        checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL full_freed_ack got=%b exp=1", m1_ack); end
        exp_q.push_back('{id: 1'b1, data: next_data});
        next_data++;
        step();
        idle();
        test_drain();
    endtask

    task automatic test_interleave();
        int          ids[3]  = '{0, 1, 0};
        logic [31:0] dats[3] = '{32'hA, 32'hB, 32'hC};
        idle();
        s_ack = 1;
        for (int i = 0; i < 3; i++) begin
            m0_req = 0; m1_req = 0;
            set_m(ids[i], 0, 32'h800 + 4 * i);
            #3;
            checks++; if ({m1_ack, m0_ack} !== (ids[i] == 1 ? 2'b10 : 2'b01)) begin failures++; $display("FAIL il_ack i=%0d got=%b%b", i, m1_ack, m0_ack); end
            exp_q.push_back('{id: ids[i][0], data: dats[i]});
            step();
        end
        idle();
        test_drain();
    endtask

    task automatic test_empty_resp();
        idle();
        s_resp = 1; s_rdata = 32'hDEAD;
        #3;
        checks++; if (m0_resp !== 1'b0 || m1_resp !== 1'b0) begin failures++; $display("FAIL empty_resp got=%b%b exp=00", m1_resp, m0_resp); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL empty_err_early got=%b exp=0", err_o); end
        step();
        idle();
        #3;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL empty_err_set got=%b exp=1", err_o); end
        step(); step(); step();
        #3;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL empty_err_sticky got=%b exp=1", err_o); end
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        s_ack = 1;
        for (int i = 0; i < 2; i++) begin
            set_m(0, 0, 32'h900 + 4 * i);
            #3;
            checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL rmid_ack i=%0d got=%b exp=1", i, m0_ack); end
            step();
        end
        rst_i = 0;
        s_resp = 1; s_rdata = 32'h1234;
        #1;
        checks++; if (m0_ack !== 1'b0 || s_req !== 1'b0 || s_addr !== 32'h0) begin failures++; $display("FAIL rmid_req got=%b/%b/%h exp=0/0/0", m0_ack, s_req, s_addr); end
        checks++; if (m0_resp !== 1'b0 || m0_rdata !== 32'h0) begin failures++; $display("FAIL rmid_resp got=%b/%h exp=0/0", m0_resp, m0_rdata); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rmid_err_clr got=%b exp=0", err_o); end
        step(); step();
        idle();
        rst_i = 1;
        #3;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rmid_err_after got=%b exp=0", err_o); end
        step();
        s_resp = 1; s_rdata = 32'h4321;
        #3;
        checks++; if (m0_resp !== 1'b0 || m1_resp !== 1'b0) begin failures++; $display("FAIL rmid_late_resp got=%b%b exp=00", m1_resp, m0_resp); end
        step();
        idle();
        #3;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL rmid_late_err got=%b exp=1", err_o); end
        step();
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fifo_full();
        test_interleave();
        test_empty_resp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
